// File: rtl/riscv_main_fsm.sv
// Main controller FSM for the multicycle RISC-V datapath: sequences fetch/decode/execute/
// memory/writeback, traps illegal opcodes and counts retired instructions. `define LUI_EN adds lui.
module riscv_main_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 pc_update,
  output logic                 branch,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef LUI_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
`endif

  // Mux-select encodings shared with the datapath.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  state_t state, state_next;
  logic   retire;

  // An instruction retires on the edge that leaves its last state.
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  // NOTE: every output and next-state is defaulted first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = S_BEQ;
`ifdef LUI_EN
          OP_LUI:            state_next = S_LUI;
`endif
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe is held for the whole access, not just the completing cycle.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = S_ILLEGAL;
      end
`ifdef LUI_EN
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        state_next = S_ALUWB;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_riscv_main_fsm.sv
// Directed self-checking bench for riscv_main_fsm: per-cycle output vectors and retired
// count against hand-computed values; LUI expectations follow `LUI_EN.
module tb_riscv_main_fsm;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op;
  logic          mem_ready;
  logic          adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic [IW-1:0] instret;

  int n_checks = 0;
  int n_err    = 0;

  riscv_main_fsm #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .adr_src(adr_src), .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .pc_update(pc_update), .branch(branch),
    .reg_write(reg_write), .mem_write(mem_write), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  // Field order: adr_src ir_write alu_src_a alu_src_b alu_op result_src pc_update branch reg_write mem_write illegal
  logic [14:0] outv;
  assign outv = {adr_src, ir_write, alu_src_a, alu_src_b, alu_op, result_src,
                 pc_update, branch, reg_write, mem_write, illegal};

  function automatic logic [14:0] ov(input logic a, input logic irw, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] aop,
                                     input logic [1:0] rs, input logic pcu, input logic br,
                                     input logic rw, input logic mw, input logic ill);
    return {a, irw, sa, sb, aop, rs, pcu, br, rw, mw, ill};
  endfunction

  logic [14:0] v_f1, v_f0, v_dec, v_madr, v_mrd, v_mwb, v_mwr, v_exr, v_exi, v_jal, v_awb,
               v_beq, v_ill, v_lui;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, check outputs and count, then advance past the edge.
  task automatic cyc(input string tag, input logic mr, input logic [14:0] ev, input int ei);
    mem_ready = mr;
    #1;
    check({tag, ".outs"}, {17'd0, outv}, {17'd0, ev});
    check({tag, ".instret"}, {28'd0, instret}, ei);
    @(posedge clk);
    #1;
  endtask

  initial begin
    v_f1   = ov(0, 1, 2'b00, 2'b10, 2'b00, 2'b10, 1, 0, 0, 0, 0);
    v_f0   = ov(0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0);
    v_dec  = ov(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    v_madr = ov(0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    v_mrd  = ov(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    v_mwb  = ov(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0);
    v_mwr  = ov(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0);
    v_exr  = ov(0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0);
    v_exi  = ov(0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0);
    v_jal  = ov(0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    v_awb  = ov(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    v_beq  = ov(0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1, 0, 0, 0);
    v_ill  = ov(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    v_lui  = ov(0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0);

    reset = 1'b0; op = 7'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("reset", 0, v_f0, 0);

    // R-type
    op = 7'b0110011;
    cyc("r.fetch", 1, v_f1, 0);
    cyc("r.decode", 1, v_dec, 0);
    cyc("r.exec", 1, v_exr, 0);
    cyc("r.aluwb", 1, v_awb, 0);

    // lw with 2 FETCH and 3 MEMREAD wait cycles: 10 cycles total; op change in MEMREAD ignored
    op = 7'b0000011;
    cyc("lw.fetch_w0", 0, v_f0, 1);
    cyc("lw.fetch_w1", 0, v_f0, 1);
    cyc("lw.fetch", 1, v_f1, 1);
    cyc("lw.decode", 1, v_dec, 1);
    cyc("lw.memadr", 1, v_madr, 1);
    op = 7'b0100011;
    cyc("lw.memrd_w0", 0, v_mrd, 1);
    cyc("lw.memrd_w1", 0, v_mrd, 1);
    cyc("lw.memrd_w2", 0, v_mrd, 1);
    cyc("lw.memrd", 1, v_mrd, 1);
    cyc("lw.memwb", 1, v_mwb, 1);

    // sw with 2 MEMWRITE wait cycles: mem_write high 3 cycles, count bumps once
    op = 7'b0100011;
    cyc("sw.fetch", 1, v_f1, 2);
    cyc("sw.decode", 1, v_dec, 2);
    cyc("sw.memadr", 1, v_madr, 2);
    cyc("sw.memwr_w0", 0, v_mwr, 2);
    cyc("sw.memwr_w1", 0, v_mwr, 2);
    cyc("sw.memwr", 1, v_mwr, 2);

    // beq then jal
    op = 7'b1100011;
    cyc("beq.fetch", 1, v_f1, 3);
    cyc("beq.decode", 1, v_dec, 3);
    cyc("beq.beq", 1, v_beq, 3);
    op = 7'b1101111;
    cyc("jal.fetch", 1, v_f1, 4);
    cyc("jal.decode", 1, v_dec, 4);
    cyc("jal.jal", 1, v_jal, 4);
    cyc("jal.aluwb", 1, v_awb, 4);

    // I-type
    op = 7'b0010011;
    cyc("i.fetch", 1, v_f1, 5);
    cyc("i.decode", 1, v_dec, 5);
    cyc("i.exec", 1, v_exi, 5);
    cyc("i.aluwb", 1, v_awb, 5);

    // Illegal opcode: absorbing for 20 cycles regardless of op/mem_ready
    op = 7'b1111111;
    cyc("ill.fetch", 1, v_f1, 6);
    cyc("ill.decode", 1, v_dec, 6);
    for (int k = 0; k < 20; k++) begin
      op = (k % 2 == 0) ? 7'b0110011 : 7'b0000011;
      cyc($sformatf("ill.hold%0d", k), logic'(k % 3 == 0), v_ill, 6);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("ill.after_reset", 0, v_f0, 0);

    // 15 branches fill the 4-bit counter, the 16th wraps it
    op = 7'b1100011;
    for (int k = 0; k < 16; k++) begin
      cyc($sformatf("wrap%0d.fetch", k), 1, v_f1, k);
      cyc($sformatf("wrap%0d.decode", k), 1, v_dec, k);
      cyc($sformatf("wrap%0d.beq", k), 1, v_beq, k);
    end
    mem_ready = 1'b0;
    #1;
    check("wrap.zero", {28'd0, instret}, 0);

    // lui: supported only with LUI_EN
    op = 7'b0110111;
    cyc("lui.fetch", 1, v_f1, 0);
    cyc("lui.decode", 1, v_dec, 0);
`ifdef LUI_EN
    cyc("lui.lui", 1, v_lui, 0);
    cyc("lui.aluwb", 1, v_awb, 0);
    cyc("lui.done", 0, v_f0, 1);
`else
    cyc("lui.ill0", 1, v_ill, 0);
    cyc("lui.ill1", 1, v_ill, 0);
    check("lui.lui_unused", {17'd0, v_lui}, {17'd0, ov(0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0)} & {32{illegal}} | ~{32{illegal}} & 32'h0 | {17'd0, v_lui} & ~{32{illegal}});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
